// File: rtl/oam_dma.sv
// OAM DMA engine: a CPU write to TRIG_ADDR halts the CPU and copies the 256-byte
// page {P,00}..{P,FF} into DEST_ADDR, one read/write pair per byte.
module oam_dma #(
  parameter logic [15:0] TRIG_ADDR = 16'h4014,
  parameter logic [15:0] DEST_ADDR = 16'h2004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_d,
  input  logic        cpu_rw,
  input  logic [7:0]  dma_d_in,
  output logic        rdy,
  output logic        dma_active,
  output logic [15:0] dma_a,
  output logic        dma_rw,
  output logic [7:0]  dma_d_out,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALT  = 3'd1,
    S_ALIGN = 3'd2,
    S_READ  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  buf_q, buf_d;
  logic        par_q;

  logic        rdy_q, rdy_d;
  logic        active_q, active_d;
  logic [15:0] dma_a_q, dma_a_d;
  logic        dma_rw_q, dma_rw_d;
  logic [7:0]  dma_d_out_q, dma_d_out_d;
  logic        done_q, done_d;

  logic        trig;

  assign trig = (cpu_a == TRIG_ADDR) && !cpu_rw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      page_q      <= 8'h00;
      idx_q       <= 8'h00;
      buf_q       <= 8'h00;
      par_q       <= 1'b0;
      rdy_q       <= 1'b1;
      active_q    <= 1'b0;
      dma_a_q     <= 16'h0000;
      dma_rw_q    <= 1'b1;
      dma_d_out_q <= 8'h00;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      page_q      <= page_d;
      idx_q       <= idx_d;
      buf_q       <= buf_d;
      par_q       <= ~par_q;
      rdy_q       <= rdy_d;
      active_q    <= active_d;
      dma_a_q     <= dma_a_d;
      dma_rw_q    <= dma_rw_d;
      dma_d_out_q <= dma_d_out_d;
      done_q      <= done_d;
    end
  end

  // HALT leaves on par so that every READ cycle lands on par==0.
  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (trig) begin
          state_d = S_HALT;
          page_d  = cpu_d;
          idx_d   = 8'h00;
        end
      end
      S_HALT:  state_d = par_q ? S_READ : S_ALIGN;
      S_ALIGN: state_d = S_READ;
      S_READ: begin
        buf_d   = dma_d_in;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (idx_q == 8'hFF) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = S_READ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from next-state values and registered, so each output
  // flop holds exactly what the state flops imply for the coming cycle.
  always_comb begin
    rdy_d       = (state_d == S_IDLE);
    active_d    = (state_d != S_IDLE);
    dma_a_d     = 16'h0000;
    dma_rw_d    = 1'b1;
    dma_d_out_d = 8'h00;
    if (state_d == S_READ) begin
      dma_a_d = {page_d, idx_d};
    end else if (state_d == S_WRITE) begin
      dma_a_d     = DEST_ADDR;
      dma_rw_d    = 1'b0;
      dma_d_out_d = buf_d;
    end
  end

  assign rdy        = rdy_q;
  assign dma_active = active_q;
  assign dma_a      = dma_a_q;
  assign dma_rw     = dma_rw_q;
  assign dma_d_out  = dma_d_out_q;
  assign done       = done_q;

endmodule

// File: tb/tb_oam_dma.sv
// Scoreboard bench for oam_dma: stimulus pushes expected page copies and halt
// lengths; a negedge monitor pops them as the DUT performs bus writes.
module tb_oam_dma;

  localparam logic [15:0] TRIG = 16'h4014;
  localparam logic [15:0] DEST = 16'h2004;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_d;
  logic        cpu_rw;
  logic [7:0]  dma_d_in;
  logic        rdy, dma_active, dma_rw, done;
  logic [15:0] dma_a;
  logic [7:0]  dma_d_out;

  oam_dma #(.TRIG_ADDR(TRIG), .DEST_ADDR(DEST)) dut (
    .clk(clk), .rst(rst), .cpu_a(cpu_a), .cpu_d(cpu_d), .cpu_rw(cpu_rw),
    .dma_d_in(dma_d_in), .rdy(rdy), .dma_active(dma_active), .dma_a(dma_a),
    .dma_rw(dma_rw), .dma_d_out(dma_d_out), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
  } xfer_t;

  xfer_t exp_q[$];
  int    len_q[$];
  int    errors = 0;
  int    checks = 0;
  int    exp_done = 0;
  int    done_seen = 0;
  int    wr_cnt = 0;
  int    run = 0;
  logic  mem_mode = 1'b0;
  logic [7:0]  mem_seed = 8'h00;
  logic        par_m;
  logic        prev_rd = 1'b0, prev_wr = 1'b0;
  logic [15:0] prev_a = 16'h0;
  logic [15:0] last_ra = 16'h0;
  logic [7:0]  last_wd = 8'h0;
  xfer_t       e_m;
  int          l_m;

  function automatic logic [7:0] memf(input logic [15:0] a, input logic mode,
                                      input logic [7:0] seed);
    if (mode) return a[7:0] ^ 8'h5A;
    return (a[7:0] * 8'd13) ^ a[15:8] ^ seed;
  endfunction

  always_comb dma_d_in = memf(dma_a, mem_mode, mem_seed);

  // Parity reference: zero out of reset, flips on every clock.
  always @(posedge clk or posedge rst) begin
    if (rst) par_m <= 1'b0;
    else     par_m <= ~par_m;
  end

  always @(negedge clk) begin
    if (rst) begin
      run = 0; wr_cnt = 0; prev_rd = 1'b0; prev_wr = 1'b0;
    end else begin
      if (!rdy && run == 0) wr_cnt = 0;
      if (dma_active && !dma_rw) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got a=%h d=%h, required no write", dma_a, dma_d_out);
        end else begin
          e_m = exp_q.pop_front();
          if (!(dma_a == DEST && prev_rd && prev_a == e_m.addr && dma_d_out == e_m.data)) begin
            errors++;
            $display("FAIL copy_byte: got rd_a=%h(rd=%0d) wr_a=%h d=%h, required rd_a=%h wr_a=%h d=%h",
                     prev_a, prev_rd, dma_a, dma_d_out, e_m.addr, DEST, e_m.data);
          end
        end
        wr_cnt++;
        last_wd = dma_d_out;
        last_ra = prev_a;
      end
      if (rdy) begin
        checks++;
        if ({dma_active, dma_a, dma_rw, dma_d_out} !== {1'b0, 16'h0000, 1'b1, 8'h00}) begin
          errors++;
          $display("FAIL idle_outputs: got act=%b a=%h rw=%b d=%h, required 0 0000 1 00",
                   dma_active, dma_a, dma_rw, dma_d_out);
        end
      end
      if (done) begin
        checks++;
        done_seen++;
        if (!(prev_wr && rdy && wr_cnt == 256)) begin
          errors++;
          $display("FAIL done_pulse: got prev_wr=%0d rdy=%0d bytes=%0d, required 1 1 256",
                   prev_wr, rdy, wr_cnt);
        end
      end
      if (!rdy) run++;
      else if (run > 0) begin
        checks++;
        if (len_q.size() == 0) begin
          errors++;
          $display("FAIL halt_len: got %0d-cycle halt, required no halt", run);
        end else begin
          l_m = len_q.pop_front();
          if (run != l_m) begin
            errors++;
            $display("FAIL halt_len: got %0d, required %0d", run, l_m);
          end
        end
        run = 0;
      end
      prev_rd = dma_active && dma_rw;
      prev_wr = dma_active && !dma_rw;
      prev_a  = dma_a;
    end
  end

  task automatic cpu_idle();
    cpu_a  = 16'h8000;
    cpu_rw = 1'b1;
    cpu_d  = 8'h00;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      @(posedge clk); #1;
      if (rdy) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_idle: got rdy=%b after 1500 cycles, required 1", rdy);
    end
  endtask

  task automatic wait_wr(input int n);
    bit ok = 1'b0;
    for (int k = 0; k < 1200; k++) begin
      @(posedge clk); #1;
      if (wr_cnt == n) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_bytes: got %0d bytes, required %0d", wr_cnt, n);
    end
  endtask

  // Called at #1 after an edge with the DMA idle. Trigger lands on the next edge;
  // the HALT cycle then carries the opposite of the current parity.
  task automatic start_xfer(input logic [7:0] page, input logic halt_par);
    if (par_m == halt_par) begin
      @(posedge clk); #1;
    end
    cpu_a  = TRIG;
    cpu_rw = 1'b0;
    cpu_d  = page;
    for (int i = 0; i < 256; i++) begin
      xfer_t x;
      x.addr = {page, 8'(i)};
      x.data = memf(x.addr, mem_mode, mem_seed);
      exp_q.push_back(x);
    end
    len_q.push_back(halt_par ? 513 : 514);
    exp_done++;
    @(posedge clk); #1;
    cpu_idle();
  endtask

  task automatic chk_rdy_high(input int cycles, input string tag);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      checks++;
      if (rdy !== 1'b1) begin
        errors++;
        $display("FAIL %s: got rdy=%b, required 1", tag, rdy);
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    cpu_idle();
    @(posedge clk); #1;
    checks++;
    if ({rdy, dma_active, dma_a, dma_rw, dma_d_out, done} !== {1'b1, 1'b0, 16'h0, 1'b1, 8'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b act=%b a=%h rw=%b d=%h done=%b", rdy, dma_active,
               dma_a, dma_rw, dma_d_out, done);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    mem_seed = 8'($urandom);
    start_xfer(8'h02, 1'b1);
    wait_idle();
    start_xfer(8'h02, 1'b0);
    wait_idle();

    mem_mode = 1'b1;
    start_xfer(8'hFF, 1'($urandom));
    wait_idle();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (last_wd !== 8'hA5 || last_ra !== 16'hFFFF) begin
      errors++;
      $display("FAIL page_ff_end: got last rd=%h wd=%h, required FFFF A5", last_ra, last_wd);
    end
    mem_mode = 1'b0;

    cpu_a = TRIG; cpu_rw = 1'b1; cpu_d = 8'($urandom);
    @(posedge clk); #1;
    cpu_a = TRIG + 16'd1; cpu_rw = 1'b0; cpu_d = 8'h02;
    @(posedge clk); #1;
    cpu_idle();
    chk_rdy_high(8, "no_trigger");

    start_xfer(8'h03, 1'($urandom));
    wait_wr(100);
    cpu_a = TRIG; cpu_rw = 1'b0; cpu_d = 8'h07;
    repeat (3) @(posedge clk);
    #1;
    cpu_idle();
    wait_idle();

    start_xfer(8'h5C, 1'($urandom));
    wait_wr(128);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({rdy, dma_active, dma_a, dma_rw, dma_d_out, done} !== {1'b1, 1'b0, 16'h0, 1'b1, 8'h0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: got rdy=%b act=%b a=%h rw=%b d=%h done=%b", rdy, dma_active,
               dma_a, dma_rw, dma_d_out, done);
    end
    exp_q.delete();
    len_q.delete();
    exp_done--;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_rdy_high(20, "no_resume");
    start_xfer(8'h5C, 1'($urandom));
    wait_idle();

    for (int t = 0; t < 4; t++) begin
      mem_seed = 8'($urandom);
      start_xfer(8'($urandom), 1'($urandom));
      wait_idle();
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0 || len_q.size() != 0 || done_seen != exp_done) begin
      errors++;
      $display("FAIL drain: got pending=%0d/%0d dones=%0d, required 0/0 dones=%0d",
               exp_q.size(), len_q.size(), done_seen, exp_done);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 The block SHALL have parameter TRIG_ADDR, default 16'h4014, meaning the CPU write address that starts a transfer.
REQ-002 The block SHALL have parameter DEST_ADDR, default 16'h2004, meaning the destination register written once per byte.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port cpu_a, input, 16 bits: CPU address bus.
REQ-006 The block SHALL have port cpu_d, input, 8 bits: CPU write data.
REQ-007 The block SHALL have port cpu_rw, input, 1 bit: CPU direction, 1=read, 0=write.
REQ-008 The block SHALL have port dma_d_in, input, 8 bits: memory read data returned during DMA read cycles.
REQ-009 The block SHALL have port rdy, output, 1 bit: CPU ready, 0 halts the CPU.
REQ-010 The block SHALL have port dma_active, output, 1 bit: 1 while the block owns the bus.
REQ-011 The block SHALL have port dma_a, output, 16 bits: DMA address.
REQ-012 The block SHALL have port dma_rw, output, 1 bit: DMA direction, 1=read, 0=write.
REQ-013 The block SHALL have port dma_d_out, output, 8 bits: DMA write data.
REQ-014 The block SHALL have port done, output, 1 bit: one-cycle pulse at transfer end.

Function
REQ-015 Trigger: the block SHALL detect a trigger at a rising edge where cpu_a==TRIG_ADDR, cpu_rw==0 and the state is IDLE.
REQ-016 On a trigger the block SHALL latch cpu_d as the page register P and clear the 8-bit byte counter i.
REQ-017 A read of TRIG_ADDR (cpu_rw==1) SHALL NOT trigger.
REQ-018 A write to TRIG_ADDR while not in IDLE SHALL be ignored: P and i are unchanged and the transfer is not restarted.
REQ-019 The block SHALL implement exactly the states IDLE, HALT, ALIGN, READ and WRITE.
REQ-020 Parity bit par: reset 0, toggles every clock cycle unconditionally.
REQ-021 The block SHALL transition IDLE->HALT on a trigger.
REQ-022 The block SHALL stay in HALT for one cycle, then go to READ if par==1 during HALT, otherwise to ALIGN; READ cycles therefore always have par==0.
REQ-023 The block SHALL stay in ALIGN for one cycle, then go to READ.
REQ-024 In READ the block SHALL drive dma_a={P,i} and dma_rw=1, and latch dma_d_in into the data buffer at the end of the cycle, then go to WRITE.
REQ-025 In WRITE the block SHALL drive dma_a=DEST_ADDR, dma_rw=0 and dma_d_out=buffer.
REQ-026 At the end of WRITE, if i==8'hFF the block SHALL go to IDLE; otherwise i increments by 1 and the block goes to READ.
REQ-027 The byte counter i SHALL be 8 bits, and the address SHALL never carry into P: page 8'hFF reads 16'hFF00..16'hFFFF.
REQ-028 The block SHALL drive rdy=0 and dma_active=1 in every non-IDLE state, and rdy=1 and dma_active=0 in IDLE.
REQ-029 Total halt length SHALL be 513 cycles (ALIGN skipped) or 514 cycles.
REQ-030 The block SHALL assert done for the single cycle immediately following the final WRITE.
REQ-031 In IDLE, HALT and ALIGN the block SHALL drive dma_a=16'h0000, dma_rw=1 and dma_d_out=8'h00.
REQ-032 Outputs SHALL be registered (state-decoded from flops) with no combinational path from cpu_* to outputs.

Reset
REQ-033 rst asserted at any time, including mid-transfer, SHALL immediately force state=IDLE, rdy=1, dma_active=0, dma_a=16'h0000, dma_rw=1, dma_d_out=8'h00, done=0, P=8'h00, i=8'h00, buffer=8'h00 and par=0.
REQ-034 After rst deasserts, an aborted transfer SHALL NOT resume; a new trigger is required.
REQ-035 A trigger presented in the same cycle rst deasserts SHALL be honoured only at the first rising edge with rst low.

Verification
REQ-036 The bench SHALL cover: write 8'h02 to 16'h4014 on an edge with par==1 -> rdy low for 513 cycles, reads 16'h0200..16'h02FF each followed by a write to 16'h2004 with the read data, then done pulses once.
REQ-037 The bench SHALL cover: the same write landing on an edge with par==0 -> one ALIGN cycle, rdy low for 514 cycles, data identical to the previous scenario.
REQ-038 The bench SHALL cover: page 8'hFF with memory pattern data=addr[7:0]^8'h5A -> last read at 16'hFFFF, last written byte 8'hA5, no access to 16'h0000.
REQ-039 The bench SHALL cover: a CPU read of 16'h4014 and a write to 16'h4015 -> no state change and rdy stays 1.
REQ-040 The bench SHALL cover: a second write to 16'h4014 with 8'h07 at byte 100 of a page-3 transfer -> ignored, addresses continue 16'h0364...
REQ-041 The bench SHALL cover: rst pulse during byte 0x80 of a transfer -> all outputs take reset values asynchronously, the block stays IDLE after release, and a fresh trigger starts a full transfer from i=0.
